mem_access_ctrl: RTL and testbench

- Memory-stage controller that drives the MEM/WB pipeline latch inputs (the producer end of the MEM/WB interface).
- Takes the EX/MEM payload, runs the data-memory request/dhit handshake and captures load data.
- Generates the latch `en` and `flush` controls, plus a stall back to upstream stages while an access is outstanding.
- Sits between the EX/MEM latch, the datapath dcache port and the MEM/WB latch.

---
 rtl/mem_access_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module  : mem_access_ctrl
// Brief   : MEM-stage controller. Runs the dcache request/dhit handshake,
//           captures load data and drives the MEM/WB latch inputs, enable,
//           flush and the upstream stall. Optional counters: MEM_ACCESS_PERF_EN
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dREN_i,
    input  logic              dWEN_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] store_i,
    input  logic [WORD_W-1:0] imm_in,
    input  logic [WORD_W-1:0] pc4_in,
    input  logic [REG_W-1:0]  wsel_in,
    input  logic              RegWr_in,
    input  logic [1:0]        MemToReg_in,
    input  logic              halt_in,
    input  logic              flush_req,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] imm_i,
    output logic [WORD_W-1:0] pc4_i,
    output logic [WORD_W-1:0] OutputPort_i,
    output logic [WORD_W-1:0] dmemload_i,
    output logic [REG_W-1:0]  wsel_i,
    output logic              RegWr_i,
    output logic              halt_i,
    output logic [1:0]        MemToReg_i,
    output logic              memwb_en,
    output logic              memwb_flush,
`ifdef MEM_ACCESS_PERF_EN
    output logic [31:0]       mem_access_cnt,
    output logic [31:0]       mem_stall_cnt,
`endif
    output logic              mem_stall
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY   = 2'd1,
        S_DONE   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_load_q;
    logic              r_flush_pend;
    logic              r_ren;
    logic              r_wen;
    logic              w_req;

    assign w_req = dREN_i | dWEN_i;

    assign imm_i        = imm_in;
    assign pc4_i        = pc4_in;
    assign wsel_i       = wsel_in;
    assign RegWr_i      = RegWr_in;
    assign MemToReg_i   = MemToReg_in;
    assign OutputPort_i = addr_i;
    assign halt_i       = halt_in;
    assign dmemaddr     = addr_i;
    assign dmemstore    = store_i;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_load_q     <= '0;
            r_flush_pend <= 1'b0;
            r_ren        <= 1'b0;
            r_wen        <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_ren        <= dREN_i & ~dWEN_i;
                        r_wen        <= dWEN_i;
                        r_flush_pend <= flush_req;
                        r_state      <= S_BUSY;
                    end else if (halt_in) begin
                        r_state <= S_HALTED;
                    end
                end
                S_BUSY: begin
                    r_flush_pend <= r_flush_pend | flush_req;
                    if (dhit) begin
                        // Stores complete through the same path but must not disturb load data.
                        if (r_ren) begin
                            r_load_q <= dmemload;
                        end
                        r_ren   <= 1'b0;
                        r_wen   <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_flush_pend <= 1'b0;
                    r_state      <= halt_in ? S_HALTED : S_IDLE;
                end
                S_HALTED: begin
                    r_state <= S_HALTED;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Issue-cycle strobes come straight from the inputs; gating with RST keeps
    // an in-flight request from re-issuing while reset is held.
    always_comb begin
        dmemREN     = 1'b0;
        dmemWEN     = 1'b0;
        mem_stall   = 1'b0;
        memwb_en    = 1'b1;
        memwb_flush = 1'b0;
        dmemload_i  = dmemload;
        unique case (r_state)
            S_IDLE: begin
                dmemREN     = ~RST & dREN_i & ~dWEN_i;
                dmemWEN     = ~RST & dWEN_i;
                mem_stall   = ~RST & w_req;
                memwb_en    = ~w_req;
                memwb_flush = ~w_req & flush_req;
            end
            S_BUSY: begin
                dmemREN   = r_ren;
                dmemWEN   = r_wen;
                mem_stall = 1'b1;
                memwb_en  = 1'b0;
            end
            S_DONE: begin
                memwb_flush = r_flush_pend | flush_req;
                dmemload_i  = r_load_q;
            end
            S_HALTED: begin
                mem_stall = 1'b1;
                memwb_en  = 1'b0;
            end
            default: begin
                memwb_en = 1'b1;
            end
        endcase
    end

`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] r_access_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_access_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (r_state == S_IDLE && w_req) begin
                r_access_cnt <= r_access_cnt + 32'd1;
            end
            if (mem_stall && r_state != S_HALTED) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign mem_access_cnt = r_access_cnt;
    assign mem_stall_cnt  = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module  : tb_mem_access_ctrl
// Brief   : Directed self-checking bench for mem_access_ctrl.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    logic              CLK;
    logic              RST;
    logic              dREN_i;
    logic              dWEN_i;
    logic [WORD_W-1:0] addr_i;
    logic [WORD_W-1:0] store_i;
    logic [WORD_W-1:0] imm_in;
    logic [WORD_W-1:0] pc4_in;
    logic [REG_W-1:0]  wsel_in;
    logic              RegWr_in;
    logic [1:0]        MemToReg_in;
    logic              halt_in;
    logic              flush_req;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic [WORD_W-1:0] imm_i;
    logic [WORD_W-1:0] pc4_i;
    logic [WORD_W-1:0] OutputPort_i;
    logic [WORD_W-1:0] dmemload_i;
    logic [REG_W-1:0]  wsel_i;
    logic              RegWr_i;
    logic              halt_i;
    logic [1:0]        MemToReg_i;
    logic              memwb_en;
    logic              memwb_flush;
    logic              mem_stall;
`ifdef MEM_ACCESS_PERF_EN
    logic [31:0]       mem_access_cnt;
    logic [31:0]       mem_stall_cnt;
`endif

    int r_checks;
    int r_errors;

    mem_access_ctrl #(.WORD_W(WORD_W), .REG_W(REG_W)) u_dut (
        .CLK          (CLK),
        .RST          (RST),
        .dREN_i       (dREN_i),
        .dWEN_i       (dWEN_i),
        .addr_i       (addr_i),
        .store_i      (store_i),
        .imm_in       (imm_in),
        .pc4_in       (pc4_in),
        .wsel_in      (wsel_in),
        .RegWr_in     (RegWr_in),
        .MemToReg_in  (MemToReg_in),
        .halt_in      (halt_in),
        .flush_req    (flush_req),
        .dhit         (dhit),
        .dmemload     (dmemload),
        .dmemREN      (dmemREN),
        .dmemWEN      (dmemWEN),
        .dmemaddr     (dmemaddr),
        .dmemstore    (dmemstore),
        .imm_i        (imm_i),
        .pc4_i        (pc4_i),
        .OutputPort_i (OutputPort_i),
        .dmemload_i   (dmemload_i),
        .wsel_i       (wsel_i),
        .RegWr_i      (RegWr_i),
        .halt_i       (halt_i),
        .MemToReg_i   (MemToReg_i),
        .memwb_en     (memwb_en),
        .memwb_flush  (memwb_flush),
`ifdef MEM_ACCESS_PERF_EN
        .mem_access_cnt (mem_access_cnt),
        .mem_stall_cnt  (mem_stall_cnt),
`endif
        .mem_stall    (mem_stall)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then updated 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Compact check of the handshake/control outputs: {REN, WEN, stall, en, flush}.
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        #1;
        chk(tag, {27'd0, dmemREN, dmemWEN, mem_stall, memwb_en, memwb_flush}, {27'd0, exp});
    endtask

    initial begin
        r_checks    = 0;
        r_errors    = 0;
        RST         = 1'b1;
        dREN_i      = 1'b0;
        dWEN_i      = 1'b0;
        addr_i      = '0;
        store_i     = '0;
        imm_in      = 32'h0000_0ABC;
        pc4_in      = 32'h0000_0104;
        wsel_in     = 5'd7;
        RegWr_in    = 1'b0;
        MemToReg_in = 2'd2;
        halt_in     = 1'b0;
        flush_req   = 1'b0;
        dhit        = 1'b0;
        dmemload    = '0;
        tick();
        tick();
        RST = 1'b0;

        // Reset state and plain non-memory flow
        chk_ctl("reset_ctl", 5'b00010);
        addr_i   = 32'h10;
        RegWr_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_ctl("nomem_ctl", 5'b00010);
            chk("nomem_outport", OutputPort_i, 32'h10);
            tick();
        end
        chk("pass_imm", imm_i, 32'h0000_0ABC);
        chk("pass_pc4", pc4_i, 32'h0000_0104);
        chk("pass_misc", {24'd0, wsel_i, RegWr_i, MemToReg_i}, {24'd0, 5'd7, 1'b1, 2'd2});
        flush_req = 1'b1;
        chk_ctl("idle_flush", 5'b00011);
        flush_req = 1'b0;

        // Load from 0x40, dhit in the third stall cycle
        addr_i = 32'h40;
        dREN_i = 1'b1;
        chk_ctl("ld_issue", 5'b10100);
        chk("ld_addr", dmemaddr, 32'h40);
        tick();
        chk_ctl("ld_busy1", 5'b10100);
        tick();
        dhit     = 1'b1;
        dmemload = 32'hDEAD_BEEF;
        chk_ctl("ld_busy2", 5'b10100);
        tick();
        dhit     = 1'b0;
        dmemload = 32'h0000_0000;
        dREN_i   = 1'b0;
        chk_ctl("ld_done", 5'b00010);
        chk("ld_done_data", dmemload_i, 32'hDEAD_BEEF);
        tick();
        dmemload = 32'h0000_1234;
        chk_ctl("ld_idle", 5'b00010);
        chk("ld_idle_data", dmemload_i, 32'h0000_1234);

        // Store with both requests set: write wins, load_q untouched
        addr_i  = 32'h80;
        store_i = 32'hCAFE_0001;
        dREN_i  = 1'b1;
        dWEN_i  = 1'b1;
        chk_ctl("st_issue", 5'b01100);
        chk("st_data", dmemstore, 32'hCAFE_0001);
        tick();
        dhit     = 1'b1;
        dmemload = 32'h5555_5555;
        chk_ctl("st_busy", 5'b01100);
        tick();
        dhit   = 1'b0;
        dREN_i = 1'b0;
        dWEN_i = 1'b0;
        chk_ctl("st_done", 5'b00010);
        chk("st_loadq_kept", dmemload_i, 32'hDEAD_BEEF);
        tick();

        // Flush request arriving while a load is outstanding
        addr_i = 32'h44;
        dREN_i = 1'b1;
        chk_ctl("fl_issue", 5'b10100);
        tick();
        flush_req = 1'b1;
        chk_ctl("fl_busy1", 5'b10100);
        tick();
        flush_req = 1'b0;
        dhit      = 1'b1;
        dmemload  = 32'h1357_9BDF;
        chk_ctl("fl_busy2", 5'b10100);
        tick();
        dhit   = 1'b0;
        dREN_i = 1'b0;
        chk_ctl("fl_done", 5'b00011);
        chk("fl_done_data", dmemload_i, 32'h1357_9BDF);
        tick();
        chk_ctl("fl_after", 5'b00010);

        // dhit in IDLE is ignored
        dhit = 1'b1;
        chk_ctl("idle_dhit", 5'b00010);
        tick();
        dhit = 1'b0;
        chk_ctl("idle_dhit_next", 5'b00010);

        // Reset while BUSY aborts at once
        dREN_i = 1'b1;
        tick();
        chk_ctl("rst_busy", 5'b10100);
        RST = 1'b1;
        #1;
        chk("rst_ren", {31'd0, dmemREN}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        RST    = 1'b0;
        dREN_i = 1'b0;
        chk_ctl("rst_after", 5'b00010);
        tick();

        // Halt: one writeback cycle, then frozen until reset
        halt_in = 1'b1;
        chk_ctl("halt_idle", 5'b00010);
        chk("halt_i", {31'd0, halt_i}, 32'd1);
        tick();
        halt_in = 1'b0;
        dREN_i  = 1'b1;
        dhit    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_ctl("halted", 5'b00100);
            tick();
        end
        dREN_i = 1'b0;
        dhit   = 1'b0;
        RST    = 1'b1;
        tick();
        RST = 1'b0;
        chk_ctl("halt_exit_rst", 5'b00010);

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

endmodule

`default_nettype wire
